// File: rtl/panda_ssi_pkg.sv
// Shared SSI definitions: FSM states, width limits and Gray-code helpers.
// Used by the encoder slave (Gray encode) and the SSI master (Gray decode).
package panda_ssi_pkg;

  localparam int SSI_MAX_BITS            = 32;
  localparam int SSI_MONO_CYCLES_DEFAULT = 2500;  // 20 us at 125 MHz

  typedef enum logic [1:0] {
    IDLE,
    LATCHED,
    SHIFT,
    MONO
  } ssi_state_e;

  // Binary to reflected Gray code.
  function automatic logic [SSI_MAX_BITS-1:0] ssi_bin2gray(input logic [SSI_MAX_BITS-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Reflected Gray code back to binary (prefix XOR from the MSB down).
  function automatic logic [SSI_MAX_BITS-1:0] ssi_gray2bin(input logic [SSI_MAX_BITS-1:0] g);
    logic [SSI_MAX_BITS-1:0] b;
    b[SSI_MAX_BITS-1] = g[SSI_MAX_BITS-1];
    for (int i = SSI_MAX_BITS - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/ssi_sck_sync.sv
// Brings the asynchronous SSI clock pad into the clk_i domain and produces
// single-cycle rise/fall pulses. All stages idle high like a parked SCK.
module ssi_sck_sync (
  input  logic clk_i,
  input  logic resetn_i,
  input  logic sck_i,
  output logic sck_o,
  output logic rise_o,
  output logic fall_o
);

  logic sync1_reg;
  logic sync2_reg;
  logic prev_reg;

  // Two-stage synchronizer followed by the edge-detect history register.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      sync1_reg <= 1'b1;
      sync2_reg <= 1'b1;
      prev_reg  <= 1'b1;
    end else begin
      sync1_reg <= sck_i;
      sync2_reg <= sync1_reg;
      prev_reg  <= sync2_reg;
    end
  end

  assign sck_o  = sync2_reg;
  assign rise_o = sync2_reg & ~prev_reg;
  assign fall_o = ~sync2_reg & prev_reg;

endmodule

// File: rtl/ssi_encoder_slave.sv
// Absolute SSI encoder emulation: latches the position on the master's first
// falling SCK edge, shifts it out MSB first on rising edges, then holds data
// low until SCK has stayed high for MONO_CYCLES clocks (monoflop).
module ssi_encoder_slave
  import panda_ssi_pkg::*;
#(
  parameter int MONO_CYCLES = SSI_MONO_CYCLES_DEFAULT,
  parameter int MAX_BITS    = SSI_MAX_BITS
) (
  input  logic                clk_i,
  input  logic                resetn_i,
  input  logic                enable_i,
  input  logic [5:0]          bits_i,
  input  logic                gray_i,
  input  logic [MAX_BITS-1:0] posn_i,
  input  logic                ssi_sck_i,
  output logic                ssi_dat_o,
  output logic                busy_o,
  output logic                frame_done_o
);

  localparam int               CNT_W    = $clog2(MONO_CYCLES + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(MONO_CYCLES - 1);
  localparam logic [5:0]       BITS_MAX = 6'(MAX_BITS);

  logic sck_level, sck_rise, sck_fall;

  ssi_sck_sync u_sck_sync (
    .clk_i    (clk_i),
    .resetn_i (resetn_i),
    .sck_i    (ssi_sck_i),
    .sck_o    (sck_level),
    .rise_o   (sck_rise),
    .fall_o   (sck_fall)
  );

  ssi_state_e          state_reg, state_next;
  logic [MAX_BITS-1:0] shreg_reg, shreg_next;
  logic [5:0]          bitcnt_reg, bitcnt_next;
  logic [CNT_W-1:0]    tmo_reg, tmo_next;
  logic                dat_reg, dat_next;
  logic                busy_reg, busy_next;
  logic                done_reg, done_next;

  // Frame word preparation: clamp length, mask, optional Gray, left-justify.
  logic [5:0]          eff_bits;
  logic [MAX_BITS:0]   mask_wide;
  logic [MAX_BITS-1:0] field, coded, latch_word;
  logic                tmo_expire;

  assign eff_bits   = (bits_i == 6'd0 || bits_i > BITS_MAX) ? BITS_MAX : bits_i;
  assign mask_wide  = ((MAX_BITS+1)'(1) << eff_bits) - (MAX_BITS+1)'(1);
  assign field      = posn_i & mask_wide[MAX_BITS-1:0];
  assign coded      = gray_i ? MAX_BITS'(ssi_bin2gray(SSI_MAX_BITS'(field))) : field;
  assign latch_word = coded << (BITS_MAX - eff_bits);
  // A rising edge in the same cycle always takes precedence over expiry.
  assign tmo_expire = sck_level && !sck_rise && (tmo_reg == TMO_LAST);

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_reg  <= IDLE;
      shreg_reg  <= '0;
      bitcnt_reg <= '0;
      tmo_reg    <= '0;
      dat_reg    <= 1'b1;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      shreg_reg  <= shreg_next;
      bitcnt_reg <= bitcnt_next;
      tmo_reg    <= tmo_next;
      dat_reg    <= dat_next;
      busy_reg   <= busy_next;
      done_reg   <= done_next;
    end
  end

  // Next-state, shifter, bit counter and monoflop counter.
  always_comb begin
    state_next  = state_reg;
    shreg_next  = shreg_reg;
    bitcnt_next = bitcnt_reg;
    dat_next    = dat_reg;
    done_next   = 1'b0;

    // Counts consecutive high cycles; any low level or edge restarts it.
    if (!sck_level || sck_rise) tmo_next = '0;
    else if (!tmo_expire)       tmo_next = tmo_reg + CNT_W'(1);
    else                        tmo_next = tmo_reg;

    unique case (state_reg)
      IDLE: begin
        dat_next = 1'b1;
        tmo_next = '0;
        if (sck_fall) begin
          state_next  = LATCHED;
          shreg_next  = latch_word;
          bitcnt_next = eff_bits;
        end
      end
      LATCHED, SHIFT: begin
        if (sck_rise) begin
          dat_next    = shreg_reg[MAX_BITS-1];
          shreg_next  = {shreg_reg[MAX_BITS-2:0], 1'b0};
          bitcnt_next = bitcnt_reg - 6'd1;
          if (bitcnt_reg == 6'd1) begin
            done_next  = 1'b1;
            state_next = MONO;
          end else begin
            state_next = SHIFT;
          end
        end else if (tmo_expire) begin
          // Master gave up mid-frame: return quietly, no completion pulse.
          state_next  = IDLE;
          dat_next    = 1'b1;
          shreg_next  = '0;
          bitcnt_next = '0;
          tmo_next    = '0;
        end
      end
      MONO: begin
        // LSB stays valid for the master's final falling edge; the next
        // rising edge parks the line low until the monoflop expires.
        if (sck_rise) dat_next = 1'b0;
        if (tmo_expire) begin
          state_next = IDLE;
          dat_next   = 1'b1;
          tmo_next   = '0;
        end
      end
      default: state_next = IDLE;
    endcase

    if (!enable_i) begin
      state_next  = IDLE;
      dat_next    = 1'b1;
      done_next   = 1'b0;
      shreg_next  = '0;
      bitcnt_next = '0;
      tmo_next    = '0;
    end

    busy_next = (state_next != IDLE);
  end

  assign ssi_dat_o    = dat_reg;
  assign busy_o       = busy_reg;
  assign frame_done_o = done_reg;

endmodule

// File: tb/tb_ssi_encoder_slave.sv
// Directed bench for ssi_encoder_slave acting as an SSI master.
module tb_ssi_encoder_slave;

  localparam int MONO = 40;   // short monoflop keeps the run brief
  localparam int HALF = 8;    // SCK half-period in clk cycles

  logic        clk = 1'b0;
  logic        resetn;
  logic        enable;
  logic [5:0]  bits;
  logic        gray;
  logic [31:0] posn;
  logic        ssi_sck;
  logic        ssi_dat;
  logic        busy;
  logic        frame_done;

  int n_vec = 0;
  int n_err = 0;
  int done_cnt = 0;

  ssi_encoder_slave #(.MONO_CYCLES(MONO), .MAX_BITS(32)) dut (
    .clk_i        (clk),
    .resetn_i     (resetn),
    .enable_i     (enable),
    .bits_i       (bits),
    .gray_i       (gray),
    .posn_i       (posn),
    .ssi_sck_i    (ssi_sck),
    .ssi_dat_o    (ssi_dat),
    .busy_o       (busy),
    .frame_done_o (frame_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_done === 1'b1) done_cnt++;

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
    $display("vec %0d %s observed 0x%0h expected 0x%0h", n_vec, tag, obs, exp);
  endtask

  // Full master frame: nbits+1 SCK clocks, sampling data on falling edges.
  task automatic run_frame(input int nbits, input int change_at,
                           input logic [31:0] new_posn, output logic [31:0] rx);
    rx = '0;
    ssi_sck = 1'b0;
    wait_cyc(HALF);
    for (int i = 0; i < nbits; i++) begin
      if (i == change_at) posn = new_posn;
      ssi_sck = 1'b1;
      wait_cyc(HALF);
      rx = {rx[30:0], ssi_dat};
      ssi_sck = 1'b0;
      wait_cyc(HALF);
    end
    ssi_sck = 1'b1;
  endtask

  // Start a 16-bit frame of posn=0x0F0F and stop just after the 4th bit (a 0).
  task automatic partial_frame();
    bits = 6'd16;
    posn = 32'h0F0F;
    ssi_sck = 1'b0;
    wait_cyc(HALF);
    for (int i = 0; i < 3; i++) begin
      ssi_sck = 1'b1;
      wait_cyc(HALF);
      ssi_sck = 1'b0;
      wait_cyc(HALF);
    end
    ssi_sck = 1'b1;
    wait_cyc(5);
  endtask

  initial begin
    logic [31:0] rx;
    int d0;

    resetn  = 1'b0;
    enable  = 1'b1;
    bits    = 6'd24;
    gray    = 1'b0;
    posn    = 32'h0;
    ssi_sck = 1'b1;
    wait_cyc(4);
    check("reset_dat", 32'(ssi_dat), 32'h1);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_done", 32'(frame_done), 32'h0);
    resetn = 1'b1;
    wait_cyc(5);

    // Binary 24-bit frame and monoflop timing.
    d0 = done_cnt;
    bits = 6'd24;
    posn = 32'h00A5C3;
    run_frame(24, -1, 32'h0, rx);
    check("bin24_data", rx, 32'h00A5C3);
    wait_cyc(6);
    check("bin24_dat_low", 32'(ssi_dat), 32'h0);
    check("bin24_busy", 32'(busy), 32'h1);
    check("bin24_done_once", 32'(done_cnt - d0), 32'h1);
    wait_cyc(24);
    check("mono_hold_dat", 32'(ssi_dat), 32'h0);
    wait_cyc(20);
    check("mono_end_dat", 32'(ssi_dat), 32'h1);
    check("mono_end_busy", 32'(busy), 32'h0);

    // Gray frames.
    gray = 1'b1;
    bits = 6'd8;
    posn = 32'h80;
    run_frame(8, -1, 32'h0, rx);
    check("gray_80", rx, 32'hC0);
    wait_cyc(MONO + 10);
    posn = 32'h05;
    run_frame(8, -1, 32'h0, rx);
    check("gray_05", rx, 32'h07);
    wait_cyc(MONO + 10);
    gray = 1'b0;

    // Position changes mid-frame are ignored.
    bits = 6'd16;
    posn = 32'h1234;
    run_frame(16, 3, 32'hFFFF, rx);
    check("midframe_posn", rx, 32'h1234);
    wait_cyc(MONO + 10);

    // Master abort after 5 of 16 bits.
    d0 = done_cnt;
    posn = 32'hFFFF;
    ssi_sck = 1'b0;
    wait_cyc(HALF);
    for (int i = 0; i < 5; i++) begin
      ssi_sck = 1'b1;
      wait_cyc(HALF);
      ssi_sck = 1'b0;
      wait_cyc(HALF);
    end
    ssi_sck = 1'b1;
    wait_cyc(8);
    check("abort_busy_before", 32'(busy), 32'h1);
    wait_cyc(MONO + 2);
    check("abort_dat", 32'(ssi_dat), 32'h1);
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_no_done", 32'(done_cnt - d0), 32'h0);
    posn = 32'hBEEF;
    run_frame(16, -1, 32'h0, rx);
    check("after_abort_data", rx, 32'hBEEF);
    wait_cyc(MONO + 10);

    // Falling edges during MONO retrigger the monoflop.
    d0 = done_cnt;
    bits = 6'd8;
    posn = 32'h5A;
    run_frame(8, -1, 32'h0, rx);
    check("retrig_data", rx, 32'h5A);
    wait_cyc(20);
    ssi_sck = 1'b0;
    wait_cyc(4);
    ssi_sck = 1'b1;
    wait_cyc(30);
    check("retrig_dat_low", 32'(ssi_dat), 32'h0);
    check("retrig_busy", 32'(busy), 32'h1);
    wait_cyc(20);
    check("retrig_end_dat", 32'(ssi_dat), 32'h1);
    check("retrig_done_once", 32'(done_cnt - d0), 32'h1);

    // Enable dropped mid-shift.
    partial_frame();
    check("en_pre_dat", 32'(ssi_dat), 32'h0);
    enable = 1'b0;
    wait_cyc(1);
    check("en_off_dat", 32'(ssi_dat), 32'h1);
    check("en_off_busy", 32'(busy), 32'h0);
    enable = 1'b1;
    wait_cyc(MONO + 10);
    check("en_idle_busy", 32'(busy), 32'h0);

    // Reset pulse mid-frame.
    partial_frame();
    check("rst_pre_busy", 32'(busy), 32'h1);
    resetn = 1'b0;
    #1;
    check("rst_mid_dat", 32'(ssi_dat), 32'h1);
    check("rst_mid_busy", 32'(busy), 32'h0);
    check("rst_mid_done", 32'(frame_done), 32'h0);
    wait_cyc(2);
    resetn = 1'b1;
    wait_cyc(MONO + 10);

    // Out-of-range lengths mean a full 32-bit frame.
    posn = 32'hDEADBEEF;
    bits = 6'd0;
    run_frame(32, -1, 32'h0, rx);
    check("bits0_data", rx, 32'hDEADBEEF);
    wait_cyc(MONO + 10);
    bits = 6'd40;
    run_frame(32, -1, 32'h0, rx);
    check("bits40_data", rx, 32'hDEADBEEF);
    wait_cyc(MONO + 10);
    check("final_dat", 32'(ssi_dat), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
